// File: rtl/dff_bank_univ.sv
// dff_bank_univ: WIDTH-bit register bank with active-low sync clear/set, enable,
// parallel load, shift, rotate and up/down count modes, true/complement outputs.
module dff_bank_univ #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             set,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_cmp,
    output logic             sout_l,
    output logic             sout_r,
    output logic             zero,
    output logic             carry
);
    logic [WIDTH-1:0] nxt;
    logic             wrap;

    always_comb begin
        nxt  = q;
        wrap = 1'b0;
        case (mode)
            3'b001: nxt = d;
            3'b010: nxt = {q[WIDTH-2:0], sin_r};
            3'b011: nxt = {sin_l, q[WIDTH-1:1]};
            3'b100: nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            3'b101: nxt = {q[0], q[WIDTH-1:1]};
            3'b110: begin
                nxt  = q + WIDTH'(1);
                wrap = &q;
            end
            3'b111: begin
                nxt  = q - WIDTH'(1);
                wrap = ~|q;
            end
            default: nxt = q;
        endcase
    end

    // carry is a one-edge pulse: every branch but an enabled wrapping count clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= RESET_VAL;
            carry <= 1'b0;
        end else if (!clr) begin
            q     <= '0;
            carry <= 1'b0;
        end else if (!set) begin
            q     <= '1;
            carry <= 1'b0;
        end else if (en) begin
            q     <= nxt;
            carry <= wrap;
        end else begin
            carry <= 1'b0;
        end
    end

    assign q_cmp  = ~q;
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    assign zero   = ~|q;
endmodule

// File: doc/dff_bank_univ.md
Name: dff_bank_univ

Overview:
- Parametrised successor to the single-bit synchronous clear/set D flip-flop: a WIDTH-bit register bank.
- Keeps the active-low synchronous clr/set priority scheme and the true/complement outputs.
- Adds enable, parallel load, shift, rotate and up/down count modes.
- Used as the general-purpose state/shift/count register in datapath and control blocks.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- RESET_VAL, {WIDTH{1'b0}}, value loaded by rst.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- clr  in  1  synchronous active-low clear (q → 0).
- set  in  1  synchronous active-low set (q → all ones).
- en  in  1  operation enable; 0 = hold.
- mode  in  3  operation select (see Behaviour).
- d  in  WIDTH  parallel load data.
- sin_l  in  1  serial in at MSB (shift right).
- sin_r  in  1  serial in at LSB (shift left).
- q  out  WIDTH  register contents.
- q_cmp  out  WIDTH  bitwise complement of q.
- sout_l  out  1  q[WIDTH-1].
- sout_r  out  1  q[0].
- zero  out  1  1 when q == 0.
- carry  out  1  registered wrap flag from count modes.

Behaviour:
- One clock. Reset is synchronous and active-high.
- State is q (WIDTH flops) and carry (1 flop). q_cmp, sout_l, sout_r and zero are combinational from q; no other logic.
- Priority at each rising clk edge, highest first:
  1. rst=1: q ← RESET_VAL, carry ← 0.
  2. clr=0: q ← 0, carry ← 0.
  3. set=0: q ← all ones, carry ← 0.
  4. en=0: q holds, carry ← 0.
  5. en=1: execute mode.
- clr=0 and set=0 together: clear wins, so q=0 and q_cmp=all ones.
- clr and set are ignored while rst=1.
- Modes (en=1):
  - 000 hold.
  - 001 load: q ← d.
  - 010 shift left: q ← {q[WIDTH-2:0], sin_r}.
  - 011 shift right: q ← {sin_l, q[WIDTH-1:1]}.
  - 100 rotate left: q ← {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 rotate right: q ← {q[0], q[WIDTH-1:1]}.
  - 110 count up: q ← q+1, modulo 2^WIDTH.
  - 111 count down: q ← q−1, modulo 2^WIDTH.
- carry ← 1 only on an edge where mode 110 wraps all-ones→0 or mode 111 wraps 0→all-ones. It is 0 after every other edge, so it is a one-cycle pulse.
- Latency: every operation takes effect at the edge where it is sampled; outputs are valid immediately after that edge.
- All inputs are sampled only at the rising edge; no asynchronous paths.
- X/Z on d propagates to q on load; the bench treats it as don't-care.
- rst mid-sequence (e.g. during counting) overrides on that edge; the next edge resumes from RESET_VAL using the then-current mode.
- Invariant at all times: q_cmp == ~q.

Test Plan:
- Reset and priority (WIDTH=8, RESET_VAL=8'hA5):
  - rst=1 with clr=0, set=0 for one edge → q=A5, q_cmp=5A, carry=0.
  - rst=0, clr=0, set=0 → q=00, zero=1.
  - clr=1, set=0 → q=FF.
- Load, hold and enable: en=1, mode=001, d=3C → q=3C. Then en=0 with mode=001, d=C3 for 3 edges → q stays 3C.
- Shift and rotate from q=81:
  - shift left with sin_r=0 → 02.
  - shift right with sin_l=1 → 81.
  - rotate left → 03.
  - rotate right → 81.
  - sout_l/sout_r track bits 7/0 each cycle.
- Count wrap:
  - load FE, mode=110 for 3 edges → q=FF, 00, 01; carry=0, 1, 0; zero=1 only while q=00.
  - load 01, mode=111 for 3 edges → q=00, FF, FE; carry=0, 1, 0.
- Reset mid-count: counting up from 10, assert rst on the 3rd edge → q=A5. Release rst → next edge q=A6.
- Exhaustive control sweep: 6-bit counter over {rst, clr, set, en, mode[1:0]} with mode[2]=1 and random d, checked every edge by a reference model. Required: error flag never set; q_cmp == ~q on every cycle.
